ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
Execute-stage RV32M multiply/divide unit. It sits directly downstream of the data hazard unit and consumes its forward_a_e/forward_b_e selects through its own operand muxes. It latches the forwarded operands on start and runs a single-cycle registered multiply or a 32-iteration restoring divide. It holds the front of the pipeline stalled until the result is ready.

Parameters:
XLEN, 32, operand/result width; the divide iteration count equals XLEN.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_e  in  1  M-extension instruction valid in Execute
funct3_e  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rd1_e  in  XLEN  register-file value for rs1
rd2_e  in  XLEN  register-file value for rs2
alu_result_m  in  XLEN  Memory-stage forwarding source
result_w  in  XLEN  Writeback-stage forwarding source
forward_a_e  in  2  operand A select from the hazard unit
forward_b_e  in  2  operand B select from the hazard unit
flush_e  in  1  kill the instruction in Execute
stall_e  out  1  hold Fetch/Decode/Execute; bubble into Memory
done_e  out  1  one-cycle pulse; result_e valid
result_e  out  XLEN  operation result

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Operand mux, per operand: 00 rd1_e/rd2_e, 01 result_w, 10 alu_result_m, 11 reserved and treated as 00.
- Operands and funct3 are captured only in the start cycle. Later changes on the forwarding sources are ignored, because M/W keep advancing while E stalls.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_e=1 and flush_e=0: capture opA, opB, funct3.
  - Next state is MUL if funct3[2]=0, else DIV; the iteration counter is cleared to 0.
- MUL (one cycle):
  - Form a 2*XLEN product with signedness per op: MULH s*s, MULHSU s*u, MULHU u*u; MUL uses the low half.
  - Register the selected half into result_e; go to DONE.
- DIV:
  - Restoring divide on operand magnitudes (signed ops: DIV, REM), one quotient bit per cycle, counter 0..XLEN-1.
  - On the last iteration, apply the sign fix-up (quotient sign = sA^sB, remainder sign = sA), register the selected quotient/remainder into result_e, and go to DONE.
- DONE: done_e=1 for exactly one cycle, stall_e=0 (the pipeline advances); next state IDLE.
- Stall rule: stall_e = (IDLE & start_e & ~flush_e) | MUL | DIV. It is combinational so the start cycle is already stalled.
- Latency, with start at cycle N:
  - Multiply: done_e at N+2.
  - Divide: done_e at N+XLEN+1 (N+33).
  - Latency is fixed and independent of operand values.
- Special cases; the divide still takes the full latency:
  - Divisor 0: quotient all-ones, remainder = dividend. Applies to signed and unsigned ops.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- result_e holds its value until the next op completes. done_e is 0 outside DONE.
- flush_e in MUL or DIV: go to IDLE the next cycle, no done_e, result_e unchanged. flush_e in DONE: ignored, because the pulse has already been issued.
- start_e is ignored outside IDLE.
- rst, at any time including mid-operation: state IDLE, counter 0, stall_e=0, done_e=0, result_e=0 from the next edge.

Test Plan:
- MUL: rd1_e=7, rd2_e=0xFFFFFFFD, fwd 00/00 → stall_e high at N and N+1; done_e at N+2 with result_e=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 → result_e=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → result_e=0xFFFFFFFE.
- DIV and REM on -7 and 2 → DIV gives result_e=0xFFFFFFFD and REM gives 0xFFFFFFFF, each with done_e exactly at N+33 and stall_e high for N..N+32.
- Divide corner cases:
  - DIVU 10/0 → 0xFFFFFFFF; REMU 10/0 → 10.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Forwarding: forward_a_e=10 with alu_result_m=100 at the start cycle, then alu_result_m=5; forward_b_e=01 with result_w=4 → DIVU result_e=25, i.e. the captured values are used.
- Abort: flush_e at cycle N+10 of a DIV → IDLE at N+11, no done_e, stall_e low. A new MUL start at N+12 completes at N+14. Asserting rst mid-DIV gives all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage M-extension bus: operands, forwarding selects, and result handshake.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_e;
  logic [2:0]      funct3_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] alu_result_m;
  logic [XLEN-1:0] result_w;
  logic [1:0]      forward_a_e;
  logic [1:0]      forward_b_e;
  logic            flush_e;
  logic            stall_e;
  logic            done_e;
  logic [XLEN-1:0] result_e;

  modport master (
    output start_e, funct3_e, rd1_e, rd2_e, alu_result_m, result_w,
    output forward_a_e, forward_b_e, flush_e,
    input  stall_e, done_e, result_e
  );

  modport slave (
    input  start_e, funct3_e, rd1_e, rd2_e, alu_result_m, result_w,
    input  forward_a_e, forward_b_e, flush_e,
    output stall_e, done_e, result_e
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: one-cycle registered multiply, XLEN-cycle restoring divide.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   bus
);
  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_sa;
  logic            r_sb;
  logic            r_done;

  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic            w_div_sgn;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  // Forwarding muxes; select 11 is reserved and falls back to the register file.
  always_comb begin
    w_opa = bus.rd1_e;
    w_opb = bus.rd2_e;
    case (bus.forward_a_e)
      2'b01:   w_opa = bus.result_w;
      2'b10:   w_opa = bus.alu_result_m;
      default: w_opa = bus.rd1_e;
    endcase
    case (bus.forward_b_e)
      2'b01:   w_opb = bus.result_w;
      2'b10:   w_opb = bus.alu_result_m;
      default: w_opb = bus.rd2_e;
    endcase
  end

  // Divide works on magnitudes; DIV/REM (funct3[0]=0) are the signed ops.
  assign w_div_sgn = ~bus.funct3_e[0];
  assign w_abs_a   = (w_div_sgn & w_opa[XLEN-1]) ? -w_opa : w_opa;
  assign w_abs_b   = (w_div_sgn & w_opb[XLEN-1]) ? -w_opb : w_opb;

  // Multiply: extend each operand by one bit with its own signedness, keep 2*XLEN.
  logic                 w_mul_sa;
  logic                 w_mul_sb;
  logic signed [XLEN:0] w_a_ext;
  logic signed [XLEN:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic [XLEN-1:0]      w_mul_res;

  assign w_mul_sa  = (r_funct3[1:0] != 2'b11);
  assign w_mul_sb  = ~r_funct3[1];
  assign w_a_ext   = {w_mul_sa & r_opa[XLEN-1], r_opa};
  assign w_b_ext   = {w_mul_sb & r_opb[XLEN-1], r_opb};
  assign w_prod    = PW'(w_a_ext) * PW'(w_b_ext);
  assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_div_res;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  // Sign fix-up, with divide-by-zero overriding the iterated result.
  always_comb begin
    w_q_fix = (r_sa ^ r_sb) ? -w_quo_nx : w_quo_nx;
    w_r_fix = r_sa ? -w_rem_nx : w_rem_nx;
    if (r_opb == '0) begin
      w_q_fix = '1;
      w_r_fix = r_opa;
    end
    w_div_res = r_funct3[1] ? w_r_fix : w_q_fix;
  end

  // Control FSM with operand capture, divide datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_e && !bus.flush_e) begin
            r_funct3 <= bus.funct3_e;
            r_opa    <= w_opa;
            r_opb    <= w_opb;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_sa     <= w_div_sgn & w_opa[XLEN-1];
            r_sb     <= w_div_sgn & w_opb[XLEN-1];
            r_cnt    <= '0;
            r_state  <= bus.funct3_e[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (bus.flush_e) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_mul_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          if (bus.flush_e) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN - 1)) begin
              r_result <= w_div_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the start cycle itself already holds the front end.
  assign bus.stall_e  = ((r_state == S_IDLE) & bus.start_e & ~bus.flush_e) |
                        (r_state == S_MUL) | (r_state == S_DIV);
  assign bus.done_e   = r_done;
  assign bus.result_e = r_result;
endmodule
